// File: rtl/adder_seq_ctrl.sv
// Word-serial M-bit adder: one shared N-bit slice, one word per clock, LS word first.
// Optional subtract mode (input sub) is enabled by defining ADDER_SEQ_SUB_EN.
module adder_seq_ctrl #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic           start,
  input  logic [N*W-1:0] A,
  input  logic [N*W-1:0] B,
`ifdef ADDER_SEQ_SUB_EN
  input  logic           sub,
`endif
  output logic           busy,
  output logic           done,
  output logic [N*W-1:0] Y,
  output logic           Cout
);

  localparam int unsigned M    = N * W;
  localparam int unsigned IdxW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state;
  logic [M-1:0]    op_a;
  logic [M-1:0]    op_b;
  logic [IdxW-1:0] idx;
  logic            carry;
  logic            sub_q;
  logic            accept;
  logic            last_word;

  logic [N-1:0]    slice_a;
  logic [N-1:0]    slice_b;
  logic [N-1:0]    slice_sum;
  logic            slice_cout;

`ifdef ADDER_SEQ_SUB_EN
  logic sub_in;
  assign sub_in = sub;
`else
  logic sub_in;
  assign sub_in = 1'b0;
`endif

  assign accept    = start && (state != StRun);
  assign last_word = (idx == IdxW'(W - 1));

  // The single shared slice; subtraction inverts the B word, the +1 comes from the initial carry.
  always_comb begin
    slice_a = op_a[idx*N +: N];
    slice_b = op_b[idx*N +: N] ^ {N{sub_q}};
    {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {{N{1'b0}}, carry};
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= StIdle;
      op_a  <= '0;
      op_b  <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sub_q <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Y     <= '0;
      Cout  <= 1'b0;
    end else if (accept) begin
      state <= StRun;
      op_a  <= A;
      op_b  <= B;
      idx   <= '0;
      carry <= sub_in;
      sub_q <= sub_in;
      busy  <= 1'b1;
      done  <= 1'b0;
      Y     <= '0;
      Cout  <= 1'b0;
    end else begin
      unique case (state)
        StRun: begin
          Y[idx*N +: N] <= slice_sum;
          carry         <= slice_cout;
          if (last_word) begin
            idx   <= '0;
            Cout  <= slice_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= StDone;
          end else begin
            idx <= idx + IdxW'(1);
          end
        end
        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          done  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl (N=4, W=2): expected {Cout,Y} queued at start,
// popped and compared whenever done pulses.
module tb_adder_seq_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned W = 2;
  localparam int unsigned M = N * W;

  logic         clk;
  logic         n_reset;
  logic         start;
  logic [M-1:0] A;
  logic [M-1:0] B;
  logic         sub;
  logic         busy;
  logic         done;
  logic [M-1:0] Y;
  logic         Cout;

  int n_vec = 0;
  int n_err = 0;
  logic [M:0] sb[$];

  adder_seq_ctrl #(.N(N), .W(W)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .start   (start),
    .A       (A),
    .B       (B),
`ifdef ADDER_SEQ_SUB_EN
    .sub     (sub),
`endif
    .busy    (busy),
    .done    (done),
    .Y       (Y),
    .Cout    (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [M:0] model(input logic [M-1:0] a, input logic [M-1:0] b,
                                       input logic s);
    logic [M:0] r;
    if (s) r = {1'b0, a} + {1'b0, ~b} + (M+1)'(1);
    else   r = {1'b0, a} + {1'b0, b};
    return r;
  endfunction

  // Scoreboard consumer: every done must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (n_reset && done) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", 32'(done), 32'd0);
      end else begin
        check_eq("sum", 32'({Cout, Y}), 32'(sb.pop_front()));
        check_eq("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Called at a negedge with the DUT idle or in its done cycle; returns at the done-cycle negedge.
  task automatic run_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic s);
    A = a; B = b; sub = s; start = 1'b1;
    sb.push_back(model(a, b, s));
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_c1", 32'(busy), 32'd1);
    check_eq("done_c1", 32'(done), 32'd0);
    @(negedge clk);
    check_eq("busy_c2", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("done_c3", 32'(done), 32'd1);
  endtask

  logic [M-1:0] bset [16];

  initial begin
    n_reset = 1'b0; start = 1'b0; A = '0; B = '0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_y", 32'(Y), 32'h0);
    check_eq("rst_cout", 32'(Cout), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_y", 32'(Y), 32'h0);
    check_eq("idle_busy", 32'(busy), 32'd0);

    // In-word carry only
    run_op(8'h3C, 8'h4F, 1'b0);
    check_eq("y_3c_4f", 32'(Y), 32'h8B);
    @(negedge clk);

    // Carry out of word 0 must land in word 1 (observed mid-run and at done)
    A = 8'hFF; B = 8'h01; start = 1'b1; sb.push_back(model(8'hFF, 8'h01, 1'b0));
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check_eq("w0_written", 32'(Y[3:0]), 32'h0);
    check_eq("w1_pending", 32'(Y[7:4]), 32'h0);
    @(negedge clk);
    check_eq("ff_01_y", 32'(Y), 32'h00);
    check_eq("ff_01_cout", 32'(Cout), 32'd1);
    run_op(8'h0F, 8'h01, 1'b0);
    check_eq("carry_into_w1", 32'(Y), 32'h10);
    @(negedge clk);

    // start held high; operands changed mid-run; back-to-back accept in the done cycle
    A = 8'h01; B = 8'h02; start = 1'b1; sb.push_back(model(8'h01, 8'h02, 1'b0));
    @(negedge clk);
    A = 8'h10; B = 8'h10; sb.push_back(model(8'h10, 8'h10, 1'b0));
    check_eq("held_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("held_busy2", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("held_done1", 32'(done), 32'd1);
    check_eq("held_y1", 32'(Y), 32'h03);
    @(negedge clk);
    start = 1'b0;
    check_eq("held_reaccept", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check_eq("held_done2", 32'(done), 32'd1);
    check_eq("held_y2", 32'(Y), 32'h20);
    @(negedge clk);

    // Reset mid-run aborts with no done
    A = 8'hF0; B = 8'h10; start = 1'b1; sb.push_back(model(8'hF0, 8'h10, 1'b0));
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    n_reset = 1'b0;
    sb.delete();
    #1;
    check_eq("abort_y", 32'(Y), 32'h0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("abort_quiet", 32'(done), 32'd0);
    run_op(8'hF0, 8'h10, 1'b0);
    check_eq("retry_y", 32'(Y), 32'h00);
    check_eq("retry_cout", 32'(Cout), 32'd1);

`ifdef ADDER_SEQ_SUB_EN
    run_op(8'h10, 8'h01, 1'b1);
    check_eq("sub_y1", 32'({Cout, Y}), 32'h10F);
    run_op(8'h01, 8'h10, 1'b1);
    check_eq("sub_y2", 32'({Cout, Y}), 32'h0F1);
`endif

    // Every A against a spread of B values, issued back-to-back
    bset[0] = 8'h00; bset[1] = 8'h01; bset[2] = 8'h0F; bset[3] = 8'h10;
    bset[4] = 8'h7F; bset[5] = 8'h80; bset[6] = 8'hF0; bset[7] = 8'hFF;
    for (int i = 8; i < 16; i++) bset[i] = 8'($urandom_range(0, 255));
    for (int a = 0; a < 256; a++) begin
      for (int j = 0; j < 16; j++) begin
`ifdef ADDER_SEQ_SUB_EN
        run_op(8'(a), bset[j], 1'($urandom_range(0, 1)));
`else
        run_op(8'(a), bset[j], 1'b0);
`endif
      end
    end
    @(negedge clk);
    repeat (2) @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
